wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master Wishbone arbiter (16-bit data, 32-bit address) between two bus masters and the single master port of wb_intercon.
- Master 0 is the moxie core; master 1 is a secondary master such as a DMA or debug loader.
- Holds a grant for the whole cycle (cyc asserted), uses round-robin under contention and steers the ack back to the granted master only.

Parameters:
- DATA_WIDTH, 16, width of all data buses.
- ADDR_WIDTH, 32, width of all address buses.
- TIMEOUT_CYCLES, 255, stall limit; used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m0_adr_i / m1_adr_i  in  ADDR_WIDTH  master address.
- m0_dat_i / m1_dat_i  in  DATA_WIDTH  master write data.
- m0_sel_i / m1_sel_i  in  2  byte selects.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_cyc_i / m1_cyc_i  in  1  cycle request.
- m0_stb_i / m1_stb_i  in  1  strobe.
- m0_dat_o / m1_dat_o  out  DATA_WIDTH  read data.
- m0_ack_o / m1_ack_o  out  1  acknowledge.
- m0_err_o / m1_err_o  out  1  bus error (timeout).
- s_adr_o  out  ADDR_WIDTH  to intercon.
- s_dat_o  out  DATA_WIDTH  to intercon.
- s_sel_o  out  2  to intercon.
- s_we_o  out  1  to intercon.
- s_cyc_o  out  1  to intercon.
- s_stb_o  out  1  to intercon.
- s_dat_i  in  DATA_WIDTH  from intercon.
- s_ack_i  in  1  from intercon.
- gnt_o  out  2  one-hot current grant: 01 = m0, 10 = m1, 00 = idle.

Behaviour:
- States: IDLE, GNT0, GNT1.
  - Registered state.
  - Reset (rst_i=0, asynchronous) forces IDLE and last_gnt=1.
- Reset values:
  - All s_* control outputs 0, gnt_o=00, all m*_ack_o and m*_err_o 0.
  - s_adr_o, s_dat_o, s_sel_o and s_we_o are 0 in IDLE.
- IDLE transitions:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high -> grant the master not equal to last_gnt.
  - Neither -> stay in IDLE.
  - Grant latency is 1 clock from cyc_i high to s_cyc_o high.
- On entering GNTn: last_gnt <= n.
- In GNTn:
  - s_adr/dat/sel/we/cyc/stb are combinational copies of master n's inputs.
  - mn_ack_o = s_ack_i; the other master's ack_o = 0.
- Read data: s_dat_i is broadcast to both m*_dat_o; it is meaningful only with ack.
- Release:
  - When the granted master's cyc_i is sampled low, return to IDLE.
  - At least one idle cycle (s_cyc_o=0) separates consecutive grants, including back-to-back requests from the same master.
- Non-preemption:
  - A grant is never revoked while the granted cyc_i is high, regardless of the other master.
  - Exception: timeout, see Optional Feature.
- Ungranted master: sees ack_o=0 and err_o=0 and simply waits; there is no error for a pending request.
- Simultaneous release and request: if the granted master drops cyc_i in the same cycle the other asserts cyc_i, go to IDLE, then grant the other master on the next edge.
- Reset mid-cycle: asynchronous return to IDLE; s_cyc_o drops immediately; no ack is forwarded.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter (wide enough for TIMEOUT_CYCLES) clears on each grant and on each s_ack_i.
  - It increments each cycle while granted and s_stb_o=1 and s_ack_i=0.
  - When the count reaches TIMEOUT_CYCLES: pulse the granted mn_err_o high for exactly 1 cycle, force s_cyc_o/s_stb_o low that cycle, and go to IDLE; the master must drop cyc_i.
- When undefined: no counter is built, m*_err_o are tied 0, and a stalled slave holds the grant indefinitely.

Test Plan:
- m0 single read of 0x1000, slave returns 0xBEEF after 2 wait states -> s_cyc_o high 1 clk after m0_cyc_i; m0_ack_o=1 with m0_dat_o=0xBEEF; m1_ack_o stays 0; gnt_o 01 -> 00.
- m0 and m1 request simultaneously from reset -> m0 granted first (gnt_o=01); after m0 drops cyc_i, 1 idle cycle, then gnt_o=10.
- Both masters request continuously for 4 transactions -> grants alternate 0,1,0,1 with one idle cycle between each.
- m1 granted with a burst of 3 acks while m0 requests -> s_adr_o tracks m1_adr_i throughout; m0_ack_o=0 for all 3; m0 granted only after m1_cyc_i falls.
- Assert rst_i=0 mid-transfer with gnt_o=10 -> s_cyc_o, gnt_o and acks go 0 without waiting for a clock edge; after release, first request is granted normally.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks m0 -> m0_err_o pulses 1 cycle after 8 stalled cycles, s_cyc_o drops, state IDLE; without the macro, the grant is held for 1000 cycles and err_o stays 0.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole cycle, ack steered to the owner.
// Optional stall timeout with error pulse, enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [1:0]            m0_sel_i,
  input  logic                  m0_we_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [1:0]            m1_sel_i,
  input  logic                  m1_we_i,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [1:0]            s_sel_o,
  output logic                  s_we_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            gnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state;
  logic   last_gnt;
  logic   timeout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW_MIN = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_MIN > 8) ? TW_MIN : 8;

  logic [TW-1:0] stall_cnt;
  logic          owner_stb;

  assign owner_stb = (state == GNT0) ? m0_stb_i : (state == GNT1) ? m1_stb_i : 1'b0;
  // An ack arriving in the limit cycle wins over the timeout.
  assign timeout   = (state != IDLE) && !s_ack_i && (stall_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (state == IDLE || s_ack_i) begin
      stall_cnt <= '0;
    end else if (owner_stb) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
            state    <= GNT0;
            last_gnt <= 1'b0;
          end else if (m1_cyc_i) begin
            state    <= GNT1;
            last_gnt <= 1'b1;
          end
        end
        GNT0:    if (!m0_cyc_i || timeout) state <= IDLE;
        GNT1:    if (!m1_cyc_i || timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i && !timeout;
        s_stb_o  = m0_stb_i && !timeout;
        m0_ack_o = s_ack_i;
        m0_err_o = timeout;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i && !timeout;
        s_stb_o  = m1_stb_i && !timeout;
        m1_ack_o = s_ack_i;
        m1_err_o = timeout;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed steps, per-master read-data scoreboards and a grant-sequence log.
module tb_wb_arbiter2;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk_i, rst_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [1:0]    m0_sel_i, m1_sel_i, s_sel_o, gnt_o;
  logic          m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic          m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i;

  wb_arbiter2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int          checks = 0;
  int          errors = 0;
  int          wait_states = 0;
  bit          slave_hang = 1'b0;
  int          ws_cnt = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [1:0]  gnt_log[$];
  int          idle_log[$];
  int          idle_run = 0;
  logic [1:0]  prev_gnt = 2'b00;

  function automatic logic [15:0] slv_data(input logic [31:0] a);
    return (a == 32'h1000) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_master(input int id, input bit cyc, input bit stb, input logic [31:0] adr,
                            input bit we, input logic [15:0] dat, input logic [1:0] sel);
    if (id == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr; m0_we_i = we; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr; m1_we_i = we; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] a);
    if (id == 0) q0.push_back(slv_data(a));
    else         q1.push_back(slv_data(a));
  endtask

  // Classic read burst of 'beats' beats; entered and left just after a falling edge.
  task automatic m_xfer(input int id, input logic [31:0] adr, input int beats);
    bit          got;
    logic [31:0] a;
    a = adr;
    set_master(id, 1, 1, a, 0, 16'h0, 2'b11);
    push_exp(id, a);
    for (int b = 0; b < beats; b++) begin
      got = 1'b0;
      for (int w = 0; w < 60 && !got; w++) begin
        @(negedge clk_i);
        got = (id == 0) ? m0_ack_o : m1_ack_o;
      end
      chk($sformatf("m%0d_ack_seen", id), got, 1);
      #1;
      if (b == beats - 1) begin
        set_master(id, 0, 0, 32'h0, 0, 16'h0, 2'b00);
      end else begin
        a = a + 2;
        set_master(id, 1, 1, a, 0, 16'h0, 2'b11);
        push_exp(id, a);
      end
    end
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    rst_i = 1'b1;
  endtask

  initial begin
    int base;
    int cnt;
    int stalls;
    int held;
    bit err_seen;

    rst_i = 1'b0;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    set_master(0, 0, 0, 32'h0, 0, 16'h0, 2'b00);
    set_master(1, 0, 0, 32'h0, 0, 16'h0, 2'b00);

    // Slave model: acks after wait_states idle cycles, data derived from the address.
    fork
      forever begin
        @(posedge clk_i); #1;
        if (s_cyc_o && s_stb_o && !s_ack_i && !slave_hang) begin
          if (ws_cnt >= wait_states) begin
            s_ack_i = 1'b1;
            s_dat_i = slv_data(s_adr_o);
            ws_cnt  = 0;
          end else begin
            ws_cnt++;
          end
        end else begin
          s_ack_i = 1'b0;
          ws_cnt  = 0;
        end
      end
      forever begin
        @(negedge clk_i);
        if (m0_ack_o) begin
          chk("m1_ack_excl", m1_ack_o, 0);
          chk("s_adr_m0", s_adr_o, m0_adr_i);
          chk("m0_ack_expected", q0.size() > 0, 1);
          if (q0.size() > 0) chk("m0_rdata", m0_dat_o, q0.pop_front());
        end
        if (m1_ack_o) begin
          chk("m0_ack_excl", m0_ack_o, 0);
          chk("s_adr_m1", s_adr_o, m1_adr_i);
          chk("m1_ack_expected", q1.size() > 0, 1);
          if (q1.size() > 0) chk("m1_rdata", m1_dat_o, q1.pop_front());
        end
        if (gnt_o == 2'b00) begin
          idle_run++;
        end else if (prev_gnt == 2'b00) begin
          gnt_log.push_back(gnt_o);
          idle_log.push_back(idle_run);
          idle_run = 0;
        end
        prev_gnt = gnt_o;
      end
    join_none

    #12;
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
    chk("rst_s_adr_we", {s_adr_o, s_we_o}, 33'h0);
    @(negedge clk_i); #1;
    rst_i = 1'b1;

    // Contention from reset: m0 wins first, then strict alternation with one idle cycle.
    wait_states = 0;
    base = gnt_log.size();
    fork
      begin m_xfer(0, 32'h0100, 1); m_xfer(0, 32'h0102, 1); end
      begin m_xfer(1, 32'h0200, 1); m_xfer(1, 32'h0202, 1); end
    join
    chk("rr_grant_count", gnt_log.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < gnt_log.size()) begin
        chk($sformatf("rr_gnt%0d", i), gnt_log[base + i], (i % 2 == 0) ? 2'b01 : 2'b10);
        if (i > 0) chk($sformatf("rr_idle%0d", i), idle_log[base + i], 1);
      end
    end

    // m0 single read of 0x1000 with two wait states.
    wait_states = 2;
    @(negedge clk_i); #1;
    set_master(0, 1, 1, 32'h1000, 0, 16'h0, 2'b11);
    push_exp(0, 32'h1000);
    #1;
    chk("rd_pre_cyc", s_cyc_o, 0);
    chk("rd_idle_adr", s_adr_o, 0);
    @(negedge clk_i);
    chk("rd_cyc_latency", s_cyc_o, 1);
    chk("rd_gnt", gnt_o, 2'b01);
    cnt = 0;
    while (!m0_ack_o && cnt < 20) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("rd_wait_states", cnt, 2);
    chk("rd_m1_ack", m1_ack_o, 0);
    #1;
    set_master(0, 0, 0, 32'h0, 0, 16'h0, 2'b00);
    @(negedge clk_i);
    chk("rd_release_gnt", gnt_o, 2'b00);
    chk("rd_release_cyc", s_cyc_o, 0);

    // m1 burst of 3 while m0 waits; m0 only after m1 releases.
    wait_states = 1;
    #1;
    base = gnt_log.size();
    fork
      m_xfer(1, 32'h2000, 3);
      begin
        repeat (2) @(negedge clk_i);
        #1;
        m_xfer(0, 32'h3000, 1);
      end
    join
    chk("burst_grant_count", gnt_log.size() - base, 2);
    if (gnt_log.size() - base == 2) begin
      chk("burst_first_m1", gnt_log[base], 2'b10);
      chk("burst_then_m0", gnt_log[base + 1], 2'b01);
      chk("burst_idle", idle_log[base + 1], 1);
    end

    // Asynchronous reset in the middle of an m1 write.
    slave_hang = 1'b1;
    @(negedge clk_i); #1;
    set_master(1, 1, 1, 32'h4000, 1, 16'h1234, 2'b10);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("wr_gnt_m1", gnt_o, 2'b10);
    chk("wr_copy", {s_adr_o, s_dat_o, s_sel_o, s_we_o}, {32'h4000, 16'h1234, 2'b10, 1'b1});
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_cyc", s_cyc_o, 0);
    chk("arst_gnt", gnt_o, 2'b00);
    chk("arst_acks", {m0_ack_o, m1_ack_o}, 2'b00);
    set_master(1, 0, 0, 32'h0, 0, 16'h0, 2'b00);
    slave_hang = 1'b0;
    #1;
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    base = gnt_log.size();
    wait_states = 0;
    m_xfer(0, 32'h5000, 1);
    chk("post_rst_grant", (gnt_log.size() > base) ? gnt_log[base] : 2'b11, 2'b01);

    // Stalled slave.
    slave_hang = 1'b1;
    @(negedge clk_i); #1;
    set_master(0, 1, 1, 32'h6000, 0, 16'h0, 2'b11);
    @(negedge clk_i);
`ifdef WB_ARB_TIMEOUT_EN
    stalls = 0;
    for (int w = 0; w < 40; w++) begin
      if (m0_err_o) break;
      if (gnt_o == 2'b01) stalls++;
      @(negedge clk_i);
    end
    chk("to_stall_cycles", stalls, TO);
    chk("to_err_pulse", m0_err_o, 1);
    chk("to_m1_err", m1_err_o, 0);
    chk("to_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
    #1;
    set_master(0, 0, 0, 32'h0, 0, 16'h0, 2'b00);
    @(negedge clk_i);
    chk("to_err_one_cycle", m0_err_o, 0);
    chk("to_idle", gnt_o, 2'b00);
`else
    held = 0;
    err_seen = 1'b0;
    for (int w = 0; w < 1000; w++) begin
      if (gnt_o == 2'b01 && s_cyc_o) held++;
      if (m0_err_o || m1_err_o) err_seen = 1'b1;
      @(negedge clk_i);
    end
    chk("hang_grant_held", held, 1000);
    chk("hang_no_err", err_seen, 0);
    #1;
    set_master(0, 0, 0, 32'h0, 0, 16'h0, 2'b00);
    @(negedge clk_i);
    chk("hang_release", gnt_o, 2'b00);
`endif
    slave_hang = 1'b0;

    chk("sb_drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
